seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CYC, default 4 (range 2..255), consecutive identical synchronized samples required before a capture.
REQ-002 clk  input  1  single system clock, all flops rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 seg_in  input  7  segment lines, active-low, bit0=a .. bit6=g.
REQ-005 an_in  input  4  digit selects, active-low, bit n selects digit n.
REQ-006 hex_out  output  16  captured nibbles, digit n at [4n+3:4n].
REQ-007 digit_valid  output  4  bit n set when hex_out nibble n holds a legal decoded value.
REQ-008 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-009 err_pulse  output  1  one-cycle pulse when a stable pattern fails to decode.

Function
REQ-010 seg_in and an_in SHALL pass through a 2-flop synchronizer; all further logic uses the second stage ("sample").
REQ-011 FSM states: IDLE, SETTLE, LOCKED; reset state IDLE.
REQ-012 IDLE -> SETTLE when sample an has exactly one bit low; counter loaded to 1.
REQ-013 SETTLE: counter increments each cycle the sample {an,seg} equals the previous cycle's; any change reloads counter to 1, or returns to IDLE if an is no longer one-hot-low.
REQ-014 SETTLE -> LOCKED at the edge where counter equals STABLE_CYC; capture happens on that same edge.
REQ-015 Pin change to capture latency SHALL be exactly STABLE_CYC+2 cycles with stable inputs (6 at default).
REQ-016 LOCKED: no recapture while sample is unchanged; any change in sample -> SETTLE (one-hot-low an) or IDLE (otherwise).
REQ-017 Decode (seg active-low, g..a): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-018 Legal capture: write nibble n, set digit_valid[n], set captured-set bit n.
REQ-019 Illegal capture: hex_out nibble n unchanged, clear digit_valid[n], pulse err_pulse; captured-set bit n not set.
REQ-020 When captured-set becomes 4'b1111, frame_valid pulses on the following edge and captured-set clears on that same edge.
REQ-021 A capture coinciding with the frame_valid edge SHALL count toward the next frame.
REQ-022 Recapturing an already-captured digit before frame completion overwrites the nibble without affecting frame progress.
REQ-023 an all-high or more than one bit low SHALL never capture.

Reset
REQ-024 rst_n low asynchronously forces: FSM IDLE, counter 0, synchronizers 0x7F/0xF, hex_out 0, digit_valid 0, captured-set 0, frame_valid 0, err_pulse 0.
REQ-025 Reset mid-SETTLE aborts the capture; after release, a full STABLE_CYC+2 settle is required.
REQ-026 Reset deassertion is consumed synchronously by the design; no output toggles on the deassertion edge.

Configuration
REQ-027 Macro SEG7_CAPTURE_ERRCNT_EN.
REQ-028 Defined: extra output err_cnt (8 bits) counts err_pulse events, saturating at 255, cleared by reset.
REQ-029 Undefined: err_cnt port absent; all other behaviour identical.

Verification
REQ-030 an_in=1110, seg_in=0110000 held 10 cycles -> hex_out[3:0]=3, digit_valid=0001 at cycle 6 exactly, no further capture.
REQ-031 Scan digits 0..3 with 1111001, 0100100, 0001000, 0001110 for 8 cycles each -> hex_out=16'hFA21, digit_valid=1111, one frame_valid pulse one cycle after the last capture.
REQ-032 an_in=1110, seg_in=1111111 held 8 cycles -> err_pulse once, digit_valid[0]=0, hex_out unchanged.
REQ-033 seg_in toggles every 3 cycles (STABLE_CYC=4) -> no capture, no err_pulse.
REQ-034 an_in=1100 held 20 cycles -> no capture; rst_n pulsed low during SETTLE -> all outputs 0 immediately, fresh settle after release.
REQ-035 With SEG7_CAPTURE_ERRCNT_EN, 300 illegal captures -> err_cnt=255.

Source files
------------

// File: rtl/seg7_capture.sv
// Captures the hex digits shown on a multiplexed, active-low 7-segment display bus.
// Optional error counter output enabled by defining SEG7_CAPTURE_ERRCNT_EN.
module seg7_capture #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] hex_out,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        err_pulse
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEG_W-1:0]   seg_s1, seg_s2, seg_prev;
    logic [AN_W-1:0]    an_s1, an_s2, an_prev;
    logic [AN_W-1:0]    captured;

    logic               same_c;
    logic               onehot_c;
    logic [1:0]         dig_idx_c;
    logic               capture_c;
    logic [4:0]         dec_c;
    logic [AN_W-1:0]    cap_set_c;

    // Returns {legal, nibble} for an active-low g..a segment pattern.
    function automatic logic [4:0] seg_decode(input logic [SEG_W-1:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer plus one-cycle history of the synchronized sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= 7'h7F;
            seg_s2   <= 7'h7F;
            seg_prev <= 7'h7F;
            an_s1    <= 4'hF;
            an_s2    <= 4'hF;
            an_prev  <= 4'hF;
        end else begin
            seg_s1   <= seg_in;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            an_s1    <= an_in;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
        end
    end

    always_comb begin
        onehot_c  = 1'b1;
        dig_idx_c = 2'd0;
        case (an_s2)
            4'b1110: dig_idx_c = 2'd0;
            4'b1101: dig_idx_c = 2'd1;
            4'b1011: dig_idx_c = 2'd2;
            4'b0111: dig_idx_c = 2'd3;
            default: onehot_c  = 1'b0;
        endcase
    end

    assign same_c = ({an_s2, seg_s2} == {an_prev, seg_prev});
    assign dec_c  = seg_decode(seg_s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture fires on the edge at which the stable count reaches STABLE_CYC.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (onehot_c) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!same_c) begin
                    if (onehot_c) begin
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
                    capture_c = 1'b1;
                    state_nxt = LOCKED;
                    cnt_nxt   = CNT_W'(STABLE_CYC);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!same_c) begin
                    if (onehot_c) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        cap_set_c = '0;
        if (capture_c && dec_c[4]) begin
            cap_set_c[dig_idx_c] = 1'b1;
        end
    end

    // Output registers and frame tracking; a capture on the frame edge seeds the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out     <= '0;
            digit_valid <= '0;
            captured    <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            if (capture_c) begin
                if (dec_c[4]) begin
                    hex_out[{dig_idx_c, 2'b00} +: 4] <= dec_c[3:0];
                    digit_valid[dig_idx_c]           <= 1'b1;
                end else begin
                    digit_valid[dig_idx_c] <= 1'b0;
                    err_pulse              <= 1'b1;
                end
            end
            if (captured == 4'hF) begin
                frame_valid <= 1'b1;
                captured    <= cap_set_c;
            end else begin
                captured <= captured | cap_set_c;
            end
        end
    end

`ifdef SEG7_CAPTURE_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (capture_c && !dec_c[4] && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized and directed bench for seg7_capture against a run-length reference model.
module tb_seg7_capture;

    localparam int unsigned STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err_pulse;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    seg7_capture #(.STABLE_CYC(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .err_pulse   (err_pulse)
`ifdef SEG7_CAPTURE_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int fv_seen  = 0;
    int err_seen = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: pin values reach the sample two edges late; a digit is
    // captured when its pattern has been sampled exactly STABLE times in a row.
    logic [10:0] m_pipe [2];
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_hex;
    logic [3:0]  m_dv;
    logic [3:0]  m_cset;
    logic        m_fv;
    logic        m_err;
    int          m_errcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [3:0] an);
        int zeros = 0;
        int idx   = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    function automatic int lookup(input logic [6:0] seg);
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == seg) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pipe[0] = {4'hF, 7'h7F};
        m_pipe[1] = {4'hF, 7'h7F};
        m_prev    = {4'hF, 7'h7F};
        m_run     = 0;
        m_hex     = '0;
        m_dv      = '0;
        m_cset    = '0;
        m_fv      = 1'b0;
        m_err     = 1'b0;
        m_errcnt  = 0;
    endtask

    task automatic model_edge();
        logic [10:0] cur;
        logic [3:0]  capset;
        int          d;
        int          v;
        cur    = m_pipe[1];
        capset = '0;
        m_fv   = 1'b0;
        m_err  = 1'b0;
        m_run  = (cur == m_prev) ? m_run + 1 : 1;
        d      = digit_of(cur[10:7]);
        if (d >= 0 && m_run == STABLE) begin
            v = lookup(cur[6:0]);
            if (v >= 0) begin
                m_hex[4*d +: 4] = 4'(v);
                m_dv[d]         = 1'b1;
                capset[d]       = 1'b1;
            end else begin
                m_dv[d] = 1'b0;
                m_err   = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        if (m_cset == 4'hF) begin
            m_fv   = 1'b1;
            m_cset = capset;
        end else begin
            m_cset = m_cset | capset;
        end
        m_prev    = cur;
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = {an_in, seg_in};
    endtask

    task automatic check_outputs();
        check("hex_out", 32'(hex_out), 32'(m_hex));
        check("digit_valid", 32'(digit_valid), 32'(m_dv));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
`ifdef SEG7_CAPTURE_ERRCNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hex"}, 32'(hex_out), 32'h0);
        check({tag, "_dv"}, 32'(digit_valid), 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_err"}, 32'(err_pulse), 32'h0);
    endtask

    task automatic cyc(input logic [3:0] an, input logic [6:0] seg);
        an_in  = an;
        seg_in = seg;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        fv_seen  += int'(frame_valid);
        err_seen += int'(err_pulse);
    endtask

    // Assert reset mid-cycle, hold across one edge, release away from the edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
        #1;
        check_outputs();
        fv_seen  = 0;
        err_seen = 0;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] one;
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        model_reset();
        #3;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single digit 3 on digit 0: capture lands on the sixth edge.
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1110, 7'b0110000);
            if (i == 4) check("lat_before", 32'(digit_valid), 32'h0);
            if (i == 5) begin
                check("lat_dv", 32'(digit_valid), 32'h1);
                check("lat_hex", 32'(hex_out[3:0]), 32'h3);
            end
        end
        check("single_hex", 32'(hex_out), 32'h0003);

        // Full frame scan 1,2,A,F.
        do_reset();
        for (int d = 0; d < 4; d++) begin
            one = 4'b0001 << d;
            for (int i = 0; i < 8; i++) begin
                case (d)
                    0: cyc(~one, 7'b1111001);
                    1: cyc(~one, 7'b0100100);
                    2: cyc(~one, 7'b0001000);
                    default: cyc(~one, 7'b0001110);
                endcase
            end
        end
        for (int i = 0; i < 4; i++) cyc(4'hF, 7'h7F);
        check("frame_hex", 32'(hex_out), 32'hFA21);
        check("frame_dv", 32'(digit_valid), 32'hF);
        check("frame_count", 32'(fv_seen), 32'd1);

        // Illegal blank pattern.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'b1110, 7'h7F);
        check("illegal_err", 32'(err_seen), 32'd1);
        check("illegal_dv0", 32'(digit_valid[0]), 32'h0);
        check("illegal_hex", 32'(hex_out), 32'h0);

        // Pattern never stable long enough.
        do_reset();
        for (int i = 0; i < 30; i++) cyc(4'b1110, ((i / 3) % 2 == 0) ? 7'b1111001 : 7'b0100100);
        check("toggle_dv", 32'(digit_valid), 32'h0);
        check("toggle_err", 32'(err_seen), 32'd0);

        // Two digits selected, then a reset in the middle of a settle.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(4'b1100, 7'b0110000);
        check("multi_dv", 32'(digit_valid), 32'h0);
        check("multi_err", 32'(err_seen), 32'd0);
        for (int i = 0; i < 4; i++) cyc(4'b1011, 7'b0011001);
        an_in  = 4'b1011;
        seg_in = 7'b0011001;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1011, 7'b0011001);
            if (i == 4) check("resettle_before", 32'(digit_valid), 32'h0);
        end
        check("resettle_hex", 32'(hex_out), 32'h0400);

        // Random bursts of held patterns.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                one = 4'b0001 << $urandom_range(0, 3);
                an  = ~one;
            end else begin
                an = 4'($urandom_range(0, 15));
            end
            seg = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
            for (int h = int'($urandom_range(1, 9)); h > 0; h--) cyc(an, seg);
        end

`ifdef SEG7_CAPTURE_ERRCNT_EN
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int h = 0; h < 5; h++) cyc((n % 2 == 0) ? 4'b1110 : 4'b1101, 7'h7F);
        end
        check("errcnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
